// File: rtl/prng_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : prng_pkg                                                        |
// | Purpose  : Shared PRNG definitions: LFSR width, tap mask, default seed,    |
// |            arbiter state type and the single LFSR next-state function      |
// |            used by every PRNG consumer so all agree on one polynomial.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package prng_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps at bits 15, 12, 5 and 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h9021;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'h0F0F;

  typedef enum logic {
    ST_WARMUP,
    ST_READY
  } prng_arb_state_t;

  // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/prng_lfsr_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prng_lfsr_step                                                  |
// | Purpose  : Registered 16-bit LFSR with step enable and parallel load.      |
// |            An all-zero load is replaced by SEED to avoid lock-up.          |
// | Ports    : clk, rst (async, active-high)                                   |
// |            en       - advance one step                                     |
// |            load     - load load_val (priority over en)                     |
// |            load_val - value to load                                        |
// |            value    - current LFSR state                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prng_lfsr_step
  import prng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= SEED;
    end else if (load) begin
      value <= (load_val == '0) ? SEED : load_val;
    end else if (en) begin
      value <= lfsr_next(value);
    end
  end

endmodule
`default_nettype wire

// File: rtl/prng_dispatch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prng_dispatch_arbiter                                           |
// | Purpose  : Shares one 16-bit LFSR among N_REQ requesters with round-robin  |
// |            one-cycle grants; the LFSR advances once per grant so every     |
// |            requester receives a distinct draw. Supports runtime reseed     |
// |            and a warm-up run of WARMUP steps after reset/reseed.           |
// | Ports    : clk, rst (async, active-high)                                   |
// |            req[N_REQ]  - level requests                                    |
// |            seed_load   - pulse: load seed_val                              |
// |            seed_val    - new seed (0 maps to SEED)                         |
// |            gnt[N_REQ]  - registered one-hot grant pulse                    |
// |            rnd_valid   - |gnt                                              |
// |            rnd_data    - random word for the granted requester             |
// |            rnd_id      - index of the granted requester                    |
// |            busy        - high during warm-up                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prng_dispatch_arbiter
  import prng_pkg::*;
#(
  parameter int                N_REQ  = 4,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED,
  parameter int                WARMUP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     seed_load,
  input  logic [LFSR_W-1:0]        seed_val,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rnd_valid,
  output logic [LFSR_W-1:0]        rnd_data,
  output logic [$clog2(N_REQ)-1:0] rnd_id,
  output logic                     busy
);

  localparam int              IDX_W     = $clog2(N_REQ);
  localparam int unsigned     C_NREQ_U  = N_REQ;
  localparam logic [7:0]      C_WARMUP  = 8'(WARMUP);
  localparam prng_arb_state_t C_START   = (WARMUP == 0) ? ST_READY : ST_WARMUP;
  localparam logic [N_REQ-1:0] C_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

  prng_arb_state_t   r_state;
  prng_arb_state_t   w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  w_win;
  logic              w_found;
  logic              w_grant;
  logic              w_lfsr_en;
  logic [N_REQ-1:0]  w_elig;
  logic [LFSR_W-1:0] w_lfsr;

  // (base + off) mod N_REQ for off < N_REQ; works for non-power-of-two N_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= C_NREQ_U) s = s - C_NREQ_U;
    return s[IDX_W-1:0];
  endfunction

  prng_lfsr_step #(
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (w_lfsr_en),
    .load     (seed_load),
    .load_val (seed_val),
    .value    (w_lfsr)
  );

  // Round-robin search from r_rr_ptr. The requester granted this cycle is
  // masked so a requester that drops req after its grant is not served twice.
  always_comb begin
    w_elig  = req & ~gnt;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < C_NREQ_U; i++) begin
      if (!w_found && w_elig[wrap_add(r_rr_ptr, i)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_rr_ptr, i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_START;
      r_cnt   <= C_WARMUP;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next state. A reseed overrides everything and restarts warm-up.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_en   = 1'b0;
    w_grant     = 1'b0;
    if (seed_load) begin
      w_state_nxt = C_START;
      w_cnt_nxt   = C_WARMUP;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          w_lfsr_en = 1'b1;
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) w_state_nxt = ST_READY;
        end
        ST_READY: begin
          w_grant   = w_found;
          w_lfsr_en = w_found;
        end
        default: w_state_nxt = C_START;
      endcase
    end
  end

  // Grant/output registers. rnd_data captures the pre-step LFSR value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      rnd_data <= '0;
      rnd_id   <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      gnt      <= C_ONE << w_win;
      rnd_data <= w_lfsr;
      rnd_id   <= w_win;
      r_rr_ptr <= wrap_add(w_win, 1);
    end else begin
      gnt      <= '0;
    end
  end

  assign rnd_valid = |gnt;
  assign busy      = (r_state == ST_WARMUP);

endmodule
`default_nettype wire

// File: tb/tb_prng_dispatch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prng_dispatch_arbiter                                        |
// | Purpose  : Self-checking bench: a WARMUP=0 instance checked cycle by cycle |
// |            against a behavioural model, plus a WARMUP=4 instance for the   |
// |            warm-up sequence.                                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_prng_dispatch_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_val = '0;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [15:0] rnd_data;
  logic [1:0]  rnd_id;
  logic        busy;

  logic [3:0]  wreq = '0;
  logic        wseed_load = 1'b0;
  logic [15:0] wseed_val = '0;
  logic [3:0]  wgnt;
  logic        wvalid;
  logic [15:0] wdata;
  logic [1:0]  wid;
  logic        wbusy;

  int checks = 0;
  int errors = 0;

  // Behavioural model state for the WARMUP=0 instance.
  logic [15:0] m_lfsr;
  logic [3:0]  m_gnt;
  logic [15:0] m_data;
  logic [1:0]  m_id;
  int          m_ptr;

  always #5 clk = ~clk;

  prng_dispatch_arbiter #(.N_REQ(4), .SEED(16'h0F0F), .WARMUP(0)) dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_val(seed_val),
    .gnt(gnt), .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_id(rnd_id), .busy(busy)
  );

  prng_dispatch_arbiter #(.N_REQ(4), .SEED(16'h0F0F), .WARMUP(4)) dut_w (
    .clk(clk), .rst(rst), .req(wreq), .seed_load(wseed_load), .seed_val(wseed_val),
    .gnt(wgnt), .rnd_valid(wvalid), .rnd_data(wdata), .rnd_id(wid), .busy(wbusy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [15:0] ref_next(input logic [15:0] s);
    return {s[14:0], s[0] ^ s[5] ^ s[12] ^ s[15]};
  endfunction

  task automatic model_reset();
    m_lfsr = 16'h0F0F;
    m_gnt  = '0;
    m_data = '0;
    m_id   = '0;
    m_ptr  = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    logic [3:0] elig;
    bit         found;
    elig  = req & ~m_gnt;
    found = 1'b0;
    m_gnt = '0;
    if (seed_load) begin
      m_lfsr = (seed_val == 16'h0000) ? 16'h0F0F : seed_val;
    end else begin
      for (int off = 0; off < 4; off++) begin
        int k;
        k = (m_ptr + off) % 4;
        if (!found && elig[k]) begin
          found    = 1'b1;
          m_gnt[k] = 1'b1;
          m_data   = m_lfsr;
          m_id     = 2'(k);
          m_lfsr   = ref_next(m_lfsr);
          m_ptr    = (k + 1) % 4;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    req = '0; wreq = '0;
    do_reset();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (rnd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rnd_valid); end
    checks++; if (rnd_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", rnd_data); end
    checks++; if (rnd_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", rnd_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wbusy !== 1'b1) begin errors++; $display("FAIL reset_wbusy got=%b exp=1", wbusy); end
  endtask

  task automatic test_single();
    req = 4'b0001;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (gnt !== m_gnt || rnd_valid !== (|m_gnt) || rnd_data !== m_data) begin
        errors++;
        $display("FAIL single c%0d gnt=%b exp=%b data=%h exp=%h", c, gnt, m_gnt, rnd_data, m_data);
      end
      checks++;
      if (gnt !== ((c % 2 == 0) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single_alt c%0d gnt=%b", c, gnt);
      end
      if (c == 0) begin
        checks++; if (rnd_data !== 16'h0F0F) begin errors++; $display("FAIL single_first got=%h exp=0f0f", rnd_data); end
      end
      if (c == 2) begin
        checks++; if (rnd_data !== 16'h1E1F) begin errors++; $display("FAIL single_second got=%h exp=1e1f", rnd_data); end
      end
    end
  endtask

  task automatic test_all_rotate();
    logic [15:0] seen[$];
    int          grants;
    int          cyc;
    req = 4'b1111;
    do_reset();
    grants = 0;
    cyc    = 0;
    while (grants < 64 && cyc < 200) begin
      tick();
      cyc++;
      checks++;
      if (gnt !== m_gnt || rnd_data !== m_data) begin
        errors++; $display("FAIL rotate cyc%0d gnt=%b exp=%b data=%h exp=%h", cyc, gnt, m_gnt, rnd_data, m_data);
      end
      if (rnd_valid === 1'b1) begin
        checks++;
        if (rnd_id !== 2'(grants % 4)) begin
          errors++; $display("FAIL rotate_id grant%0d got=%0d exp=%0d", grants, rnd_id, grants % 4);
        end
        checks++;
        foreach (seen[i]) begin
          if (seen[i] === rnd_data) begin
            errors++; $display("FAIL rotate_repeat grant%0d value=%h", grants, rnd_data);
          end
        end
        seen.push_back(rnd_data);
        grants++;
      end
    end
    checks++;
    if (grants < 64) begin errors++; $display("FAIL rotate_timeout grants=%0d exp=64", grants); end
  endtask

  task automatic test_seed_zero();
    req = 4'b0100;
    do_reset();
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL seedz_pre gnt=%b exp=0100", gnt); end
    seed_load = 1'b1; seed_val = 16'h0000;
    tick();
    seed_load = 1'b0;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL seedz_load gnt=%b busy=%b exp=0000/0", gnt, busy); end
    tick();
    checks++; if (gnt !== 4'b0100 || rnd_data !== 16'h0F0F) begin errors++; $display("FAIL seedz_grant gnt=%b data=%h exp=0100/0f0f", gnt, rnd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seedz_busy got=%b exp=0", busy); end
    req = '0;
  endtask

  task automatic test_warmup();
    logic [15:0] s4;
    s4 = 16'h0F0F;
    for (int i = 0; i < 4; i++) s4 = ref_next(s4);
    req = '0; wreq = 4'b0010;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (wbusy !== 1'b1 || wgnt !== 4'b0000) begin errors++; $display("FAIL warm_busy c%0d busy=%b gnt=%b exp=1/0000", c, wbusy, wgnt); end
      tick();
    end
    checks++; if (wbusy !== 1'b0 || wgnt !== 4'b0000) begin errors++; $display("FAIL warm_done busy=%b gnt=%b exp=0/0000", wbusy, wgnt); end
    tick();
    checks++; if (wgnt !== 4'b0010 || wvalid !== 1'b1) begin errors++; $display("FAIL warm_gnt gnt=%b valid=%b exp=0010/1", wgnt, wvalid); end
    checks++; if (wdata !== s4 || wid !== 2'd1) begin errors++; $display("FAIL warm_data data=%h id=%0d exp=%h/1", wdata, wid, s4); end
    wreq = '0;
  endtask

  task automatic test_seed_priority();
    logic [15:0] v;
    v = 16'($urandom) | 16'h0001;
    req = 4'b0001;
    do_reset();
    seed_load = 1'b1; seed_val = v;
    tick();
    seed_load = 1'b0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL prio_nogrant gnt=%b exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0001 || rnd_data !== v) begin errors++; $display("FAIL prio_grant gnt=%b data=%h exp=0001/%h", gnt, rnd_data, v); end
    tick();
    tick();
    checks++; if (gnt !== 4'b0001 || rnd_data !== ref_next(v)) begin errors++; $display("FAIL prio_next gnt=%b data=%h exp=0001/%h", gnt, rnd_data, ref_next(v)); end
    #2 rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000 || rnd_valid !== 1'b0) begin errors++; $display("FAIL async_rst gnt=%b valid=%b exp=0000/0", gnt, rnd_valid); end
    checks++; if (rnd_data !== 16'h0000) begin errors++; $display("FAIL async_rst_data got=%h exp=0000", rnd_data); end
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    model_reset();
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL no_replay gnt=%b exp=0000", gnt); end
  endtask

  task automatic test_random();
    req = '0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req       = 4'($urandom_range(0, 15));
      seed_load = ($urandom_range(0, 15) == 0);
      seed_val  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tick();
      checks++;
      if (gnt !== m_gnt || rnd_valid !== (|m_gnt) || rnd_data !== m_data || busy !== 1'b0) begin
        errors++;
        $display("FAIL random c%0d gnt=%b exp=%b data=%h exp=%h busy=%b", c, gnt, m_gnt, rnd_data, m_data, busy);
      end
      if (|m_gnt) begin
        checks++;
        if (rnd_id !== m_id) begin errors++; $display("FAIL random_id c%0d got=%0d exp=%0d", c, rnd_id, m_id); end
      end
    end
    seed_load = 1'b0;
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_rotate();
    test_seed_zero();
    test_warmup();
    test_seed_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
